// File: rtl/imhotep_pkg.sv
// Shared imhotep core types: data width, LSU operation codes and LSU FSM states.
package imhotep_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        LSU_LB,
        LSU_LH,
        LSU_LW,
        LSU_LBU,
        LSU_LHU,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } lsu_state_e;

    function automatic logic is_store(lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and lane replication, load
// extraction with sign/zero extension, and the misalignment check. Purely combinational.
module lsu_align
    import imhotep_pkg::*;
(
    input  lsu_op_e          i_op,
    input  logic [1:0]       i_addr_lo,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [3:0]       o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_rdata,
    output logic             o_misaligned
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = w_shifted;
        o_misaligned = 1'b0;
        case (i_op)
            LSU_LB:  o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LSU_LBU: o_rdata = {24'h0, w_shifted[7:0]};
            LSU_LH: begin
                o_rdata      = {{16{w_shifted[15]}}, w_shifted[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            LSU_LHU: begin
                o_rdata      = {16'h0, w_shifted[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            LSU_LW:  o_misaligned = |i_addr_lo;
            LSU_SB: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            LSU_SH: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            LSU_SW:  o_misaligned = |i_addr_lo;
            default: o_misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one transaction at a time on the req/gnt/rvalid data bus,
// returning an extended load result or a misalignment error as a one-cycle pulse.
module lsu
    import imhotep_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [XLEN-1:0]  addr_i,
    input  logic [XLEN-1:0]  wdata_i,
    input  lsu_op_e          op_i,
    output logic             resp_valid_o,
    output logic [XLEN-1:0]  resp_rdata_o,
    output logic             resp_err_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [XLEN-1:0]  data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [XLEN-1:0]  data_wdata_o,
    input  logic             data_rvalid_i,
    input  logic [XLEN-1:0]  data_rdata_i
);

    lsu_state_e      r_state;
    lsu_state_e      w_next;
    lsu_op_e         r_op;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [3:0]      r_be;
    logic            r_we;
    logic            r_err;

    lsu_op_e         w_op;
    logic [1:0]      w_addr_lo;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_rdata;
    logic            w_misaligned;
    logic            w_accept;

    // In IDLE the aligner formats the incoming request; afterwards it decodes
    // the latched op/offset for load extraction.
    assign w_op      = (r_state == LSU_IDLE) ? op_i : r_op;
    assign w_addr_lo = (r_state == LSU_IDLE) ? addr_i[1:0] : r_addr[1:0];
    assign w_accept  = (r_state == LSU_IDLE) && req_valid_i;

    lsu_align u_align (
        .i_op         (w_op),
        .i_addr_lo    (w_addr_lo),
        .i_wdata      (wdata_i),
        .i_rdata      (data_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_rdata      (w_rdata),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready_o  = 1'b0;
        data_req_o   = 1'b0;
        resp_valid_o = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    w_next = w_misaligned ? LSU_DONE : LSU_REQ;
                end
            end
            LSU_REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) begin
                    w_next = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (data_rvalid_i) begin
                    w_next = LSU_DONE;
                end
            end
            LSU_DONE: begin
                resp_valid_o = 1'b1;
                w_next       = LSU_IDLE;
            end
            default: w_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op    <= LSU_LB;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_op    <= op_i;
            r_addr  <= addr_i;
            r_wdata <= w_wdata;
            r_be    <= w_be;
            r_we    <= is_store(op_i);
            r_err   <= w_misaligned;
            r_rdata <= '0;
        end else if ((r_state == LSU_WAIT) && data_rvalid_i && !r_we) begin
            r_rdata <= w_rdata;
        end
    end

    assign data_addr_o  = {r_addr[XLEN-1:2], 2'b00};
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_wdata_o = r_wdata;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized transactions
// compared against a byte-level reference model.
module tb_lsu;
    import imhotep_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    lsu_op_e     op;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;

    lsu dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .op_i          (op),
        .resp_valid_o  (resp_valid),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_mis(lsu_op_e o, logic [31:0] a);
        int off = int'(a % 4);
        if (o == LSU_LH || o == LSU_LHU || o == LSU_SH) return (off % 2) != 0;
        if (o == LSU_LW || o == LSU_SW) return off != 0;
        return 1'b0;
    endfunction

    function automatic bit m_store(lsu_op_e o);
        return o == LSU_SB || o == LSU_SH || o == LSU_SW;
    endfunction

    function automatic logic [31:0] m_rdata(lsu_op_e o, logic [31:0] a, logic [31:0] word);
        longint w = longint'(word);
        int off = int'(a % 4);
        longint b0 = (w >> (8 * off)) & 255;
        longint v;
        if (m_store(o) || m_mis(o, a)) return 32'h0;
        case (o)
            LSU_LB:  v = (b0 >= 128) ? b0 - 256 : b0;
            LSU_LBU: v = b0;
            LSU_LH, LSU_LHU: begin
                v = b0 + 256 * ((w >> (8 * (off + 1))) & 255);
                if (o == LSU_LH && v >= 32768) v = v - 65536;
            end
            default: v = w;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_be(lsu_op_e o, logic [31:0] a);
        int off = int'(a % 4);
        if (o == LSU_SB) return 4'(1 << off);
        if (o == LSU_SH) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(lsu_op_e o, logic [31:0] d);
        if (o == LSU_SB) return (d & 32'hFF) * 32'h01010101;
        if (o == LSU_SH) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // ---------------- bus driver ----------------
    // Issues one request at cycle 0 and plays memory; reports what was observed.
    task automatic run_txn(input lsu_op_e t_op, input logic [31:0] t_addr, input logic [31:0] t_wd,
                           input logic [31:0] mem_word, input int gnt_dly, input int rv_dly,
                           output logic [31:0] o_addr, output logic [3:0] o_be,
                           output logic [31:0] o_wd, output logic o_we,
                           output bit req_seen, output bit stable, output int lat,
                           output logic [31:0] o_rd, output logic o_err, output logic rdy_after);
        int cyc = 0;
        int nreq = 0;
        int gcyc = -1;
        req_seen = 0; stable = 1; lat = -1;
        o_addr = 'x; o_be = 'x; o_wd = 'x; o_we = 'x; o_rd = 'x; o_err = 'x;
        req_valid = 1'b1; op = t_op; addr = t_addr; wdata = t_wd;
        @(posedge clk); #1;
        req_valid = 1'b0; addr = $urandom; wdata = $urandom;
        cyc = 1;
        while (cyc < 300 && lat < 0) begin
            data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = $urandom;
            if (data_req) begin
                if (!req_seen) begin
                    req_seen = 1; o_addr = data_addr; o_be = data_be; o_wd = data_wdata; o_we = data_we;
                end else if (data_addr !== o_addr || data_be !== o_be || data_wdata !== o_wd || data_we !== o_we) begin
                    stable = 0;
                end
                if (nreq == gnt_dly) begin
                    data_gnt = 1'b1; gcyc = cyc;
                end
                nreq++;
            end else if (gcyc >= 0 && cyc == gcyc + 1 + rv_dly) begin
                data_rvalid = 1'b1; data_rdata = mem_word;
            end
            if (resp_valid) begin
                lat = cyc; o_rd = resp_rdata; o_err = resp_err;
            end
            @(posedge clk); #1;
            cyc++;
        end
        data_gnt = 1'b0; data_rvalid = 1'b0;
        rdy_after = req_ready;
        if (resp_valid) stable = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; op = LSU_LB; addr = '0; wdata = '0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data_req, resp_valid, resp_err, resp_rdata, data_we, data_be, data_addr, data_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b rv=%b err=%b rd=%h we=%b be=%h a=%h wd=%h, want all 0",
                     data_req, resp_valid, resp_err, resp_rdata, data_we, data_be, data_addr, data_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_loads();
        lsu_op_e     ops[5]  = '{LSU_LW, LSU_LB, LSU_LBU, LSU_LH, LSU_LHU};
        logic [31:0] as[5]   = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] ws[5]   = '{32'hDEADBEEF, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
        logic [31:0] exp[5]  = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
        logic [31:0] a, wd, rd; logic [3:0] be; logic we, er, rdy; bit seen, st; int lat;
        for (int i = 0; i < 5; i++) begin
            run_txn(ops[i], as[i], 32'h0, ws[i], 0, 0, a, be, wd, we, seen, st, lat, rd, er, rdy);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++; $display("FAIL load_%s: rdata=%h err=%b, want %h err=0", ops[i].name(), rd, er, exp[i]);
            end
            checks++;
            if (lat !== 3 || a !== {as[i][31:2], 2'b00} || be !== 4'hF || we !== 1'b0 || rdy !== 1'b1) begin
                errors++; $display("FAIL load_bus_%0d: lat=%0d addr=%h be=%h we=%b rdy=%b, want 3 %h f 0 1",
                                   i, lat, a, be, we, rdy, {as[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_stores();
        logic [31:0] a, wd, rd; logic [3:0] be; logic we, er, rdy; bit seen, st; int lat;
        run_txn(LSU_SH, 32'h206, 32'h1234ABCD, 32'h0, 0, 0, a, be, wd, we, seen, st, lat, rd, er, rdy);
        checks++;
        if (a !== 32'h204 || be !== 4'b1100 || wd !== 32'hABCDABCD || we !== 1'b1) begin
            errors++; $display("FAIL store_sh: addr=%h be=%b wd=%h we=%b, want 204 1100 abcdabcd 1", a, be, wd, we);
        end
        checks++;
        if (lat !== 3 || rd !== 32'h0 || er !== 1'b0) begin
            errors++; $display("FAIL store_sh_resp: lat=%0d rd=%h err=%b, want 3 0 0", lat, rd, er);
        end
        run_txn(LSU_SB, 32'h205, 32'h000000AA, 32'h0, 0, 2, a, be, wd, we, seen, st, lat, rd, er, rdy);
        checks++;
        if (a !== 32'h204 || be !== 4'b0010 || wd !== 32'hAAAAAAAA || we !== 1'b1) begin
            errors++; $display("FAIL store_sb: addr=%h be=%b wd=%h we=%b, want 204 0010 aaaaaaaa 1", a, be, wd, we);
        end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL store_sb_latency: got %0d want 5", lat); end
    endtask

    task automatic test_misaligned();
        lsu_op_e     ops[2] = '{LSU_LW, LSU_SH};
        logic [31:0] as[2]  = '{32'h101, 32'h301};
        logic [31:0] a, wd, rd; logic [3:0] be; logic we, er, rdy; bit seen, st; int lat;
        for (int i = 0; i < 2; i++) begin
            run_txn(ops[i], as[i], 32'h55, 32'h12345678, 0, 0, a, be, wd, we, seen, st, lat, rd, er, rdy);
            checks++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || seen !== 1'b0 || rdy !== 1'b1) begin
                errors++; $display("FAIL misaligned_%0d: lat=%0d err=%b rd=%h bus_req=%b rdy=%b, want 1 1 0 0 1",
                                   i, lat, er, rd, seen, rdy);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, wd, rd; logic [3:0] be; logic we, er, rdy; bit seen, st; int lat;
        run_txn(LSU_SW, 32'h40, 32'hCAFEF00D, 32'h0, 3, 1, a, be, wd, we, seen, st, lat, rd, er, rdy);
        checks++;
        if (st !== 1'b1 || a !== 32'h40 || be !== 4'hF || wd !== 32'hCAFEF00D || we !== 1'b1) begin
            errors++; $display("FAIL stall_bus: stable=%b addr=%h be=%h wd=%h we=%b", st, a, be, wd, we);
        end
        checks++;
        if (lat !== 7 || er !== 1'b0) begin errors++; $display("FAIL stall_latency: got %0d err=%b want 7 0", lat, er); end
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        req_valid = 1'b1; op = LSU_LW; addr = 32'h80; wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        data_gnt = 1'b1;
        @(posedge clk); #1;
        data_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({data_req, resp_valid, resp_err, resp_rdata, data_we, data_be, data_addr, data_wdata} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: req=%b rv=%b be=%h addr=%h, want zero", data_req, resp_valid, data_be, data_addr);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        data_rvalid = 1'b1; data_rdata = 32'h11223344;
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (resp_valid !== 1'b0 || data_req !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad || req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_late_rvalid: spurious activity=%b ready=%b, want 0 1", bad, req_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, t_a, t_wd, mw; logic [3:0] be; logic we, er, rdy;
        bit seen, st, mis; int lat, g, r, elat; lsu_op_e t_op;
        for (int n = 0; n < 60; n++) begin
            t_op = lsu_op_e'($urandom_range(0, 7));
            t_a = $urandom; t_wd = $urandom; mw = $urandom;
            g = $urandom_range(0, 3); r = $urandom_range(0, 3);
            mis = m_mis(t_op, t_a);
            elat = mis ? 1 : 3 + g + r;
            run_txn(t_op, t_a, t_wd, mw, g, r, a, be, wd, we, seen, st, lat, rd, er, rdy);
            checks++;
            if (lat !== elat || er !== mis || rd !== m_rdata(t_op, t_a, mw) || rdy !== 1'b1) begin
                errors++; $display("FAIL rand_resp_%0d %s a=%h: lat=%0d err=%b rd=%h rdy=%b, want %0d %b %h 1",
                                   n, t_op.name(), t_a, lat, er, rd, rdy, elat, mis, m_rdata(t_op, t_a, mw));
            end
            checks++;
            if (mis) begin
                if (seen !== 1'b0) begin errors++; $display("FAIL rand_mis_bus_%0d: bus request seen", n); end
            end else if (!st || a !== {t_a[31:2], 2'b00} || be !== m_be(t_op, t_a) || we !== m_store(t_op) ||
                         (m_store(t_op) && wd !== m_wdata(t_op, t_wd))) begin
                errors++; $display("FAIL rand_bus_%0d %s: addr=%h be=%h wd=%h we=%b stable=%b, want %h %h %h %b 1",
                                   n, t_op.name(), a, be, wd, we, st, {t_a[31:2], 2'b00}, m_be(t_op, t_a),
                                   m_wdata(t_op, t_wd), m_store(t_op));
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
